// File: rtl/flash_cmd_pkg.sv
// Shared definitions for the StrataFlash command sequencer: request op codes,
// flash command bytes, status-register bit positions, FSM encodings and the
// status error reduction used after a program/erase poll.
package flash_cmd_pkg;

  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_PROGRAM = 2'd1,
    OP_ERASE   = 2'd2,
    OP_STATUS  = 2'd3
  } op_e;

  localparam logic [7:0] CMD_READ_ARRAY    = 8'hFF;
  localparam logic [7:0] CMD_PROGRAM       = 8'h40;
  localparam logic [7:0] CMD_ERASE_SETUP   = 8'h20;
  localparam logic [7:0] CMD_ERASE_CONFIRM = 8'hD0;
  localparam logic [7:0] CMD_READ_STATUS   = 8'h70;
  localparam logic [7:0] CMD_CLEAR_STATUS  = 8'h50;

  localparam int SR_READY     = 7;
  localparam int SR_ERASE_ERR = 5;
  localparam int SR_PROG_ERR  = 4;
  localparam int SR_VPP_ERR   = 3;
  localparam int SR_LOCK_ERR  = 1;

  // Sequencer FSM states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_NEXT  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // Position inside a request's bus-cycle list.
  typedef enum logic [2:0] {
    PH_CMD1     = 3'd0,  // first command write (FF/70/40/20)
    PH_CMD2     = 3'd1,  // program data or erase confirm
    PH_POLL_CMD = 3'd2,  // W 70 before polling
    PH_POLL_RD  = 3'd3,  // status read, repeated until ready
    PH_CLEAR    = 3'd4,  // W 50
    PH_FINAL    = 3'd5,  // W FF back to read-array mode
    PH_READ     = 3'd6,  // single read for READ / STATUS
    PH_VERIFY   = 3'd7   // optional program readback
  } phase_e;

  // Any of the failure flags reported by the device after program/erase.
  function automatic logic status_err(input logic [7:0] sr);
    return sr[SR_ERASE_ERR] | sr[SR_PROG_ERR] | sr[SR_VPP_ERR] | sr[SR_LOCK_ERR];
  endfunction

endpackage

// File: rtl/flash_bus_cycle.sv
// One bridge bus cycle: registers the request, pulses fb_start for a single
// clock, holds address/data/direction until the next start and captures
// fb_rdata on the fb_done clock. fb_done outside a cycle is ignored.
module flash_bus_cycle
  #(parameter int ADDR_W = 8)
  (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  input  logic              rw,
  output logic              busy,
  output logic              done,
  output logic [7:0]        rdata,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_wdata,
  output logic              fb_rw,
  output logic              fb_start,
  input  logic              fb_done,
  input  logic [7:0]        fb_rdata
  );

  logic              busy_r;
  logic              start_r;
  logic [ADDR_W-1:0] addr_r;
  logic [7:0]        wdata_r;
  logic              rw_r;
  logic [7:0]        rdata_r;

  // Launch, hold and complete a single bus cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r  <= 1'b0;
      start_r <= 1'b0;
      addr_r  <= '0;
      wdata_r <= 8'h00;
      rw_r    <= 1'b0;
      rdata_r <= 8'h00;
    end else begin
      start_r <= 1'b0;
      if (start && !busy_r) begin
        busy_r  <= 1'b1;
        start_r <= 1'b1;
        addr_r  <= addr;
        wdata_r <= wdata;
        rw_r    <= rw;
      end else if (busy_r && fb_done) begin
        busy_r  <= 1'b0;
        rdata_r <= fb_rdata;
      end
    end
  end

  assign busy     = busy_r;
  assign done     = busy_r & fb_done;
  assign rdata    = rdata_r;
  assign fb_addr  = addr_r;
  assign fb_wdata = wdata_r;
  assign fb_rw    = rw_r;
  assign fb_start = start_r;

endmodule

// File: rtl/flash_cmd_seq.sv
// StrataFlash command sequencer. Expands READ / PROGRAM / ERASE / STATUS
// requests into bridge bus cycles, polls status to completion with a
// saturating counter bounded by POLL_LIMIT, and returns data plus an error flag.
// Optional build macro FLASH_SEQ_VERIFY_EN: PROGRAM reads the byte back after
// the final W FF, flags a mismatch and returns the readback byte.
module flash_cmd_seq
  import flash_cmd_pkg::*;
  #(parameter int POLL_LIMIT = 1024,
    parameter int ADDR_W     = 8)
  (
  input  logic              CLK_50MHZ,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_data,
  output logic              rsp_valid,
  output logic [7:0]        rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_wdata,
  input  logic [7:0]        fb_rdata,
  output logic              fb_rw,
  output logic              fb_start,
  input  logic              fb_done
  );

  localparam int              CNT_W   = $clog2(POLL_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(POLL_LIMIT);

  state_e            state_r, state_d;
  phase_e            phase_r, phase_d;
  op_e               op_r;
  logic [ADDR_W-1:0] addr_r;
  logic [7:0]        data_r;
  logic [CNT_W-1:0]  cnt_r, cnt_d, cnt_inc_s;
  logic [7:0]        res_data_r, res_data_d;
  logic              res_err_r, res_err_d;
  logic              rsp_valid_r, rsp_valid_d;
  logic              req_ready_r, req_ready_d;
  logic              accept_s;
  logic              cyc_start_s, cyc_rw_s, cyc_busy_s, cyc_done_s;
  logic [7:0]        cyc_wdata_s, cyc_rdata_s;

  assign accept_s  = req_ready_r & req_valid;
  assign cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_W'(1);

  flash_bus_cycle #(.ADDR_W(ADDR_W)) u_bus (
    .clk      (CLK_50MHZ),
    .rst      (RST),
    .start    (cyc_start_s),
    .addr     (addr_r),
    .wdata    (cyc_wdata_s),
    .rw       (cyc_rw_s),
    .busy     (cyc_busy_s),
    .done     (cyc_done_s),
    .rdata    (cyc_rdata_s),
    .fb_addr  (fb_addr),
    .fb_wdata (fb_wdata),
    .fb_rw    (fb_rw),
    .fb_start (fb_start),
    .fb_done  (fb_done),
    .fb_rdata (fb_rdata)
  );

  // State register plus step position, poll counter and result bytes.
  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      state_r    <= ST_IDLE;
      phase_r    <= PH_CMD1;
      cnt_r      <= '0;
      res_data_r <= 8'h00;
      res_err_r  <= 1'b0;
    end else begin
      state_r    <= state_d;
      phase_r    <= phase_d;
      cnt_r      <= cnt_d;
      res_data_r <= res_data_d;
      res_err_r  <= res_err_d;
    end
  end

  // Latch the request fields at accept; they stay fixed for the whole request.
  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      op_r   <= OP_READ;
      addr_r <= '0;
      data_r <= 8'h00;
    end else if (accept_s) begin
      op_r   <= op_e'(req_op);
      addr_r <= req_addr;
      data_r <= req_data;
    end else begin
      op_r   <= op_r;
      addr_r <= addr_r;
      data_r <= data_r;
    end
  end

  // Next state: walk the step list of the latched op, deciding after each bus cycle.
  always_comb begin
    state_d    = state_r;
    phase_d    = phase_r;
    cnt_d      = cnt_r;
    res_data_d = res_data_r;
    res_err_d  = res_err_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_ISSUE;
          phase_d = PH_CMD1;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (!cyc_busy_s) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (cyc_done_s) begin
          state_d = ST_NEXT;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_NEXT: begin
        state_d = ST_ISSUE;
        case (phase_r)
          PH_CMD1: begin
            if (op_r == OP_READ || op_r == OP_STATUS) begin
              phase_d = PH_READ;
            end else begin
              phase_d = PH_CMD2;
            end
          end
          PH_CMD2:     phase_d = PH_POLL_CMD;
          PH_POLL_CMD: phase_d = PH_POLL_RD;
          PH_POLL_RD: begin
            cnt_d = cnt_inc_s;
            if (cyc_rdata_s[SR_READY]) begin
              res_data_d = cyc_rdata_s;
              res_err_d  = status_err(cyc_rdata_s);
              phase_d    = PH_CLEAR;
            end else if (cnt_inc_s == CNT_MAX) begin
              // Timed out: skip the status clear, just return to read-array.
              res_data_d = cyc_rdata_s;
              res_err_d  = 1'b1;
              phase_d    = PH_FINAL;
            end else begin
              phase_d = PH_POLL_RD;
            end
          end
          PH_CLEAR: phase_d = PH_FINAL;
          PH_FINAL: begin
`ifdef FLASH_SEQ_VERIFY_EN
            if (op_r == OP_PROGRAM) begin
              phase_d = PH_VERIFY;
            end else begin
              state_d = ST_RESP;
            end
`else
            state_d = ST_RESP;
`endif
          end
          PH_READ: begin
            res_data_d = cyc_rdata_s;
            res_err_d  = 1'b0;
            state_d    = ST_RESP;
          end
          PH_VERIFY: begin
            res_data_d = cyc_rdata_s;
            res_err_d  = res_err_r | (cyc_rdata_s != data_r);
            state_d    = ST_RESP;
          end
          default: state_d = ST_IDLE;
        endcase
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: bus-cycle request in ISSUE, handshake flags decoded from the next state.
  always_comb begin
    cyc_start_s = 1'b0;
    cyc_rw_s    = 1'b0;
    cyc_wdata_s = 8'h00;
    rsp_valid_d = (state_d == ST_RESP);
    req_ready_d = (state_d == ST_IDLE);
    if (state_r == ST_ISSUE) begin
      cyc_start_s = 1'b1;
      case (phase_r)
        PH_CMD1: begin
          case (op_r)
            OP_READ:    cyc_wdata_s = CMD_READ_ARRAY;
            OP_STATUS:  cyc_wdata_s = CMD_READ_STATUS;
            OP_PROGRAM: cyc_wdata_s = CMD_PROGRAM;
            OP_ERASE:   cyc_wdata_s = CMD_ERASE_SETUP;
            default:    cyc_wdata_s = CMD_READ_ARRAY;
          endcase
        end
        PH_CMD2: begin
          if (op_r == OP_PROGRAM) begin
            cyc_wdata_s = data_r;
          end else begin
            cyc_wdata_s = CMD_ERASE_CONFIRM;
          end
        end
        PH_POLL_CMD: cyc_wdata_s = CMD_READ_STATUS;
        PH_POLL_RD:  cyc_rw_s    = 1'b1;
        PH_CLEAR:    cyc_wdata_s = CMD_CLEAR_STATUS;
        PH_FINAL:    cyc_wdata_s = CMD_READ_ARRAY;
        PH_READ:     cyc_rw_s    = 1'b1;
        PH_VERIFY:   cyc_rw_s    = 1'b1;
        default:     cyc_wdata_s = 8'h00;
      endcase
    end else begin
      cyc_start_s = 1'b0;
    end
  end

  // Registered handshake outputs; ready and response pulse are mutually exclusive.
  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      rsp_valid_r <= 1'b0;
      req_ready_r <= 1'b1;
    end else begin
      rsp_valid_r <= rsp_valid_d;
      req_ready_r <= req_ready_d;
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = res_data_r;
  assign rsp_err   = res_err_r;

endmodule

// File: tb/tb_flash_cmd_seq.sv
// Bench for flash_cmd_seq: bridge/flash model (fb_done 4 clocks after
// fb_start, 256-byte array, scripted status register), a request-level model
// that predicts every bus cycle and response, and hand-computed checks.
module tb_flash_cmd_seq;
  import flash_cmd_pkg::*;

  localparam int PL = 8;

  logic       CLK_50MHZ = 1'b0;
  logic       RST = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'd0;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_data = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic [7:0] fb_addr;
  logic [7:0] fb_wdata;
  logic [7:0] fb_rdata = 8'h00;
  logic       fb_rw;
  logic       fb_start;
  logic       fb_done = 1'b0;

  always #10 CLK_50MHZ = ~CLK_50MHZ;

  flash_cmd_seq #(.POLL_LIMIT(PL), .ADDR_W(8)) dut (
    .CLK_50MHZ (CLK_50MHZ),
    .RST       (RST),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .fb_addr   (fb_addr),
    .fb_wdata  (fb_wdata),
    .fb_rdata  (fb_rdata),
    .fb_rw     (fb_rw),
    .fb_start  (fb_start),
    .fb_done   (fb_done)
  );

  typedef struct packed {logic rw; logic [7:0] addr; logic [7:0] wdata;} bus_t;
  typedef struct packed {logic [7:0] data; logic err;} rsp_t;

  bus_t exp_q[$];
  bus_t act_q[$];
  rsp_t rsp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  // Flash / status model configuration
  logic [7:0] mem [256];
  int         st_pre = 0;       // status reads returning 00 before st_final
  logic [7:0] st_final = 8'h80;
  bit         corrupt = 1'b0;   // program stores 3D instead of the data

  // Bridge state
  int   cd = 0;
  bit   pend = 1'b0;
  bus_t cur;
  bit   status_mode = 1'b0;
  bit   prog_next = 1'b0;
  int   st_reads = 0;
  bit   prev_start = 1'b0;
  logic [7:0] last_rsp_data = 8'h00;
  logic       last_rsp_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] status_at(input int k);
    return (k < st_pre) ? 8'h00 : st_final;
  endfunction

  task automatic push_w(input logic [7:0] a, input logic [7:0] d);
    bus_t t;
    t.rw = 1'b0; t.addr = a; t.wdata = d;
    exp_q.push_back(t);
  endtask

  task automatic push_r(input logic [7:0] a);
    bus_t t;
    t.rw = 1'b1; t.addr = a; t.wdata = 8'h00;
    exp_q.push_back(t);
  endtask

  // Request-level model: full bus-cycle list and response from the command rules.
  task automatic predict(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
    rsp_t r;
    logic [7:0] s;
    logic [7:0] prog;
    bit rdy;
    int k;
    s = 8'h00;
    r.data = 8'h00; r.err = 1'b0;
    case (op)
      2'd0: begin
        push_w(a, 8'hFF); push_r(a);
        r.data = mem[a];
      end
      2'd3: begin
        push_w(a, 8'h70); push_r(a);
        r.data = st_final;
      end
      default: begin
        push_w(a, (op == 2'd1) ? 8'h40 : 8'h20);
        push_w(a, (op == 2'd1) ? d : 8'hD0);
        push_w(a, 8'h70);
        k = 0; rdy = 1'b0;
        while (k < PL && !rdy) begin
          s = status_at(k);
          push_r(a);
          k++;
          rdy = s[7];
        end
        if (rdy) begin
          r.err = s[5] | s[4] | s[3] | s[1];
          push_w(a, 8'h50);
        end else begin
          r.err = 1'b1;
        end
        push_w(a, 8'hFF);
        r.data = s;
`ifdef FLASH_SEQ_VERIFY_EN
        if (op == 2'd1) begin
          prog = corrupt ? 8'h3D : d;
          push_r(a);
          r.err  = r.err | (prog != d);
          r.data = prog;
        end
`else
        prog = 8'h00;
`endif
      end
    endcase
    rsp_q.push_back(r);
  endtask

  // Bridge/flash model plus the per-cycle compare against the model queues.
  initial begin
    bus_t e;
    rsp_t r;
    forever begin
      @(negedge CLK_50MHZ);
      if (RST) begin
        cd = 0; fb_done = 1'b0; pend = 1'b0; status_mode = 1'b0;
        prog_next = 1'b0; st_reads = 0; prev_start = 1'b0;
      end else begin
        fb_done  = 1'b0;
        fb_rdata = 8'($urandom);
        check("rsp_ready_exclusive", {31'd0, rsp_valid & req_ready}, 32'd0);
        if (pend) begin
          check("hold_addr", {24'd0, fb_addr}, {24'd0, cur.addr});
          check("hold_rw", {31'd0, fb_rw}, {31'd0, cur.rw});
          if (!cur.rw) check("hold_wdata", {24'd0, fb_wdata}, {24'd0, cur.wdata});
          cd--;
          if (cd == 0) begin
            pend = 1'b0;
            fb_done = 1'b1;
            if (cur.rw) begin
              if (status_mode) begin
                fb_rdata = status_at(st_reads);
                st_reads++;
              end else begin
                fb_rdata = mem[cur.addr];
              end
            end else if (prog_next) begin
              mem[cur.addr] = corrupt ? 8'h3D : cur.wdata;
              prog_next = 1'b0;
              status_mode = 1'b1;
            end else begin
              case (cur.wdata)
                8'hFF: status_mode = 1'b0;
                8'h70: status_mode = 1'b1;
                8'h40: begin prog_next = 1'b1; st_reads = 0; status_mode = 1'b1; end
                8'h20: begin st_reads = 0; status_mode = 1'b1; end
                8'hD0: status_mode = 1'b1;
                default: ;
              endcase
            end
          end
        end
        if (fb_start) begin
          check("fb_start_one_clk", {31'd0, prev_start}, 32'd0);
          cur.rw = fb_rw; cur.addr = fb_addr; cur.wdata = fb_wdata;
          act_q.push_back(cur);
          pend = 1'b1;
          cd = 4;
          if (exp_q.size() == 0) begin
            check("stray_fb_start", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("bus_rw", {31'd0, fb_rw}, {31'd0, e.rw});
            check("bus_addr", {24'd0, fb_addr}, {24'd0, e.addr});
            if (!e.rw) check("bus_wdata", {24'd0, fb_wdata}, {24'd0, e.wdata});
          end
        end
        prev_start = fb_start;
        if (rsp_valid) begin
          last_rsp_data = rsp_data;
          last_rsp_err  = rsp_err;
          if (rsp_q.size() == 0) begin
            check("stray_rsp", 32'd1, 32'd0);
          end else begin
            r = rsp_q.pop_front();
            check("rsp_data", {24'd0, rsp_data}, {24'd0, r.data});
            check("rsp_err", {31'd0, rsp_err}, {31'd0, r.err});
          end
        end
      end
    end
  end

  // Issue one request and wait for its response; lat = edges from accept to rsp_valid.
  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                      input bit hold, output int lat);
    int g;
    bit got;
    g = 0;
    while (!req_ready && g < 200) begin
      @(posedge CLK_50MHZ); #1; g++;
    end
    check("ready_before_req", {31'd0, req_ready}, 32'd1);
    act_q.delete();
    predict(op, a, d);
    req_valid = 1'b1; req_op = op; req_addr = a; req_data = d;
    lat = 0; got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(posedge CLK_50MHZ); #1;
      lat++;
      if (lat == 1) begin
        if (hold) begin
          req_op = 2'd3; req_addr = 8'h99;
        end else begin
          req_valid = 1'b0;
        end
      end
      if (rsp_valid) got = 1'b1;
      else if (hold) check("hold_not_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    if (!got) check("rsp_timeout", 32'd1, 32'd0);
    @(negedge CLK_50MHZ); #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_fb_start", {31'd0, fb_start}, 32'd0);
    check("rst_fb_addr", {24'd0, fb_addr}, 32'd0);
    check("rst_fb_wdata", {24'd0, fb_wdata}, 32'd0);
    check("rst_fb_rw", {31'd0, fb_rw}, 32'd0);
  endtask

  initial begin
    int lat;
    int nr;
    bit saw50;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem[10] = 8'h5A;

    repeat (2) @(posedge CLK_50MHZ);
    #1 RST = 1'b0;
    check_reset_outputs();

    // READ addr 10: W FF, R; 15 edges accept->rsp (16 clocks inclusive, B=5)
    send(2'd0, 8'd10, 8'h00, 1'b0, lat);
    check("read_data", {24'd0, last_rsp_data}, 32'h5A);
    check("read_err", {31'd0, last_rsp_err}, 32'd0);
    check("read_ncyc", act_q.size(), 32'd2);
    if (act_q.size() == 2) begin
      check("read_c0", {15'd0, act_q[0]}, {15'd0, 1'b0, 8'd10, 8'hFF});
      check("read_c1_rw", {31'd0, act_q[1].rw}, 32'd1);
    end
    check("read_latency", lat, 32'd15);

    // STATUS: error bits do not set rsp_err
    st_pre = 0; st_final = 8'hBA;
    send(2'd3, 8'd5, 8'h00, 1'b0, lat);
    check("status_data", {24'd0, last_rsp_data}, 32'hBA);
    check("status_err", {31'd0, last_rsp_err}, 32'd0);

    // PROGRAM addr 20 data 3C, ready on third poll
    st_pre = 2; st_final = 8'h80;
    send(2'd1, 8'd20, 8'h3C, 1'b0, lat);
`ifdef FLASH_SEQ_VERIFY_EN
    check("prog_ncyc", act_q.size(), 32'd9);
    check("prog_data", {24'd0, last_rsp_data}, 32'h3C);
`else
    check("prog_ncyc", act_q.size(), 32'd8);
    check("prog_data", {24'd0, last_rsp_data}, 32'h80);
`endif
    check("prog_err", {31'd0, last_rsp_err}, 32'd0);
    if (act_q.size() >= 8) begin
      check("prog_w0", {24'd0, act_q[0].wdata}, 32'h40);
      check("prog_w1", {24'd0, act_q[1].wdata}, 32'h3C);
      check("prog_r5", {31'd0, act_q[5].rw}, 32'd1);
      check("prog_w6", {24'd0, act_q[6].wdata}, 32'h50);
      check("prog_w7", {24'd0, act_q[7].wdata}, 32'hFF);
    end

    // ERASE with status A0: erase error bit
    st_pre = 1; st_final = 8'hA0;
    send(2'd2, 8'd30, 8'h00, 1'b0, lat);
    check("erase_data", {24'd0, last_rsp_data}, 32'hA0);
    check("erase_err", {31'd0, last_rsp_err}, 32'd1);
    if (act_q.size() >= 2) check("erase_w1", {24'd0, act_q[1].wdata}, 32'hD0);

    // Poll timeout: status stuck at 00
    st_pre = 100000; st_final = 8'h00;
    send(2'd2, 8'd40, 8'h00, 1'b0, lat);
    nr = 0; saw50 = 1'b0;
    foreach (act_q[i]) begin
      if (act_q[i].rw) nr++;
      else if (act_q[i].wdata == 8'h50) saw50 = 1'b1;
    end
    check("timeout_nreads", nr, 32'd8);
    check("timeout_no50", {31'd0, saw50}, 32'd0);
    check("timeout_ncyc", act_q.size(), 32'd12);
    if (act_q.size() > 0) check("timeout_lastFF", {24'd0, act_q[act_q.size()-1].wdata}, 32'hFF);
    check("timeout_err", {31'd0, last_rsp_err}, 32'd1);

    // req_valid held through a whole PROGRAM: nothing extra accepted
    st_pre = 0; st_final = 8'h80;
    send(2'd1, 8'd50, 8'h11, 1'b1, lat);
    check("hold_err", {31'd0, last_rsp_err}, 32'd0);

    // PROGRAM with the array corrupting the byte to 3D
    corrupt = 1'b1;
    send(2'd1, 8'd60, 8'h3C, 1'b0, lat);
    corrupt = 1'b0;
`ifdef FLASH_SEQ_VERIFY_EN
    check("verify_err", {31'd0, last_rsp_err}, 32'd1);
    check("verify_data", {24'd0, last_rsp_data}, 32'h3D);
`else
    check("noverify_err", {31'd0, last_rsp_err}, 32'd0);
    check("noverify_data", {24'd0, last_rsp_data}, 32'h80);
`endif

    // RST mid-WAIT while a second request is held on req_valid
    st_pre = 100000; st_final = 8'h00;
    @(posedge CLK_50MHZ); #1;
    act_q.delete();
    predict(2'd2, 8'd70, 8'h00);
    req_valid = 1'b1; req_op = 2'd2; req_addr = 8'd70;
    @(posedge CLK_50MHZ); #1;
    req_op = 2'd3; req_addr = 8'd77;
    for (int i = 0; i < 11; i++) begin
      @(posedge CLK_50MHZ); #1;
      check("busy_not_ready", {31'd0, req_ready}, 32'd0);
    end
    check("pre_rst_ncyc", act_q.size(), 32'd2);
    if (act_q.size() > 0) check("pre_rst_first", {24'd0, act_q[0].wdata}, 32'h20);
    RST = 1'b1; req_valid = 1'b0;
    exp_q.delete(); rsp_q.delete();
    @(posedge CLK_50MHZ); #1;
    RST = 1'b0;
    check_reset_outputs();
    act_q.delete();
    repeat (12) @(posedge CLK_50MHZ);
    #1;
    check("post_rst_idle_bus", act_q.size(), 32'd0);
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);

    // Array still readable after the abort; addr 20 was programmed to 3C
    send(2'd0, 8'd20, 8'h00, 1'b0, lat);
    check("read20_data", {24'd0, last_rsp_data}, 32'h3C);

    check("exp_drained", exp_q.size(), 32'd0);
    check("rsp_drained", rsp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
